// File: rtl/spi_pkg.sv
// Shared definitions for the SPI initiator: default parameters, FSM state
// encoding and the transfer-length clamp.
package spi_pkg;

  localparam int SPI_CLK_DIV_DEFAULT  = 4;
  localparam int SPI_MAX_BITS_DEFAULT = 64;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_SCK_HI   = 3'd2,
    ST_SCK_LO   = 3'd3,
    ST_HOLD     = 3'd4,
    ST_GUARD_HI = 3'd5,
    ST_GUARD_LO = 3'd6
  } spi_state_t;

  // Requests longer than the shift registers are trimmed to their width.
  function automatic logic [6:0] clamp_len(input logic [6:0] len,
                                           input int unsigned max_bits);
    if (32'(len) > max_bits) return 7'(max_bits);
    return len;
  endfunction

endpackage

// File: rtl/spi_clkdiv.sv
// Half-period divider: o_tick is high in the last cycle of every CLK_DIV-cycle
// window; i_restart holds the count at zero so a new window starts cleanly.
module spi_clkdiv
  import spi_pkg::*;
#(
  parameter int CLK_DIV = SPI_CLK_DIV_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic i_restart,
  output logic o_tick
);

  localparam int            CW   = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_restart || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/spi_initiator.sv
// SPI mode-0 initiator: shifts up to MAX_BITS bits MSB-first, then closes the
// frame with one sck pulse while ss is high so the responder resynchronises.
module spi_initiator
  import spi_pkg::*;
#(
  parameter int CLK_DIV  = SPI_CLK_DIV_DEFAULT,
  parameter int MAX_BITS = SPI_MAX_BITS_DEFAULT
) (
  input  logic                clock,
  input  logic                reset,
  // Handshake: a request is taken on a rising clock edge where req_valid and
  // req_ready are both high; req_ready is high exactly while the FSM is IDLE,
  // including the IDLE cycle that carries the resp_valid pulse.
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [6:0]          req_len,
  input  logic [MAX_BITS-1:0] req_tx,
  output logic                resp_valid,
  output logic [MAX_BITS-1:0] resp_rx,
  output logic                busy,
  output logic                sck,
  output logic                ss,
  output logic                mosi,
  input  logic                miso,
  output spi_state_t          dbg_state
);

  spi_state_t          r_state;
  logic [6:0]          r_bits;
  logic [MAX_BITS-1:0] r_tx;
  logic [MAX_BITS-1:0] r_rx;
  logic                r_sck;
  logic                r_ss;
  logic                r_mosi;
  logic                r_resp_valid;
  logic                w_idle;
  logic                w_accept;
  logic                w_tick;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_accept = w_idle && req_valid;

  spi_clkdiv #(
    .CLK_DIV(CLK_DIV)
  ) u_clkdiv (
    .clock    (clock),
    .reset    (reset),
    .i_restart(w_idle),
    .o_tick   (w_tick)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_bits       <= '0;
      r_tx         <= '0;
      r_rx         <= '0;
      r_sck        <= 1'b0;
      r_ss         <= 1'b1;
      r_mosi       <= 1'b1;
      r_resp_valid <= 1'b0;
    end else begin
      r_resp_valid <= (r_state == ST_GUARD_LO) && w_tick;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_SETUP;
            r_bits  <= clamp_len(req_len, MAX_BITS);
            // r_tx holds the bits still to be driven, next one at the MSB.
            r_tx    <= {req_tx[MAX_BITS-2:0], 1'b0};
            r_rx    <= '0;
            r_ss    <= 1'b0;
            r_mosi  <= req_tx[MAX_BITS-1];
          end
        end
        ST_SETUP: begin
          if (w_tick) begin
            if (r_bits != 7'd0) begin
              r_sck   <= 1'b1;
              r_state <= ST_SCK_HI;
            end else begin
              r_state <= ST_HOLD;
            end
          end
        end
        ST_SCK_HI: begin
          if (w_tick) begin
            r_sck   <= 1'b0;
            r_rx    <= {r_rx[MAX_BITS-2:0], miso};
            r_bits  <= r_bits - 7'd1;
            r_mosi  <= r_tx[MAX_BITS-1];
            r_tx    <= {r_tx[MAX_BITS-2:0], 1'b0};
            r_state <= ST_SCK_LO;
          end
        end
        ST_SCK_LO: begin
          if (w_tick) begin
            if (r_bits != 7'd0) begin
              r_sck   <= 1'b1;
              r_state <= ST_SCK_HI;
            end else begin
              r_state <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (w_tick) begin
            r_ss    <= 1'b1;
            r_mosi  <= 1'b1;
            r_sck   <= 1'b1;
            r_state <= ST_GUARD_HI;
          end
        end
        ST_GUARD_HI: begin
          if (w_tick) begin
            r_sck   <= 1'b0;
            r_state <= ST_GUARD_LO;
          end
        end
        ST_GUARD_LO: begin
          if (w_tick) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = w_idle;
  assign busy       = ~w_idle;
  assign resp_valid = r_resp_valid;
  assign resp_rx    = r_rx;
  assign sck        = r_sck;
  assign ss         = r_ss;
  assign mosi       = r_mosi;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_spi_initiator.sv
// Directed bench for spi_initiator: instance A (CLK_DIV=1) with loopback,
// constant or 8-bit shift-responder miso; instance B (CLK_DIV=3) back-to-back.
module tb_spi_initiator;
  import spi_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // ---------------- instance A ----------------
  logic        req_valid_a = 1'b0, req_ready_a, resp_valid_a, busy_a;
  logic [6:0]  req_len_a = '0;
  logic [63:0] req_tx_a = '0, resp_rx_a;
  logic        sck_a, ss_a, mosi_a, miso_a;
  spi_state_t  dbg_a;
  int          miso_sel_a = 0;   // 0: constant, 1: loopback, 2: responder
  logic        miso_const = 1'b0;
  logic [7:0]  rs_sr;
  logic        rs_cap, rs_prev;

  assign miso_a = (miso_sel_a == 1) ? mosi_a : (miso_sel_a == 2) ? rs_sr[7] : miso_const;

  spi_initiator #(.CLK_DIV(1), .MAX_BITS(64)) u_dut_a (
    .clock(clock), .reset(reset), .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_len(req_len_a), .req_tx(req_tx_a), .resp_valid(resp_valid_a), .resp_rx(resp_rx_a),
    .busy(busy_a), .sck(sck_a), .ss(ss_a), .mosi(mosi_a), .miso(miso_a), .dbg_state(dbg_a)
  );

  // ---------------- instance B ----------------
  logic        req_valid_b = 1'b0, req_ready_b, resp_valid_b, busy_b;
  logic [6:0]  req_len_b = '0;
  logic [63:0] req_tx_b = '0, resp_rx_b;
  logic        sck_b, ss_b, mosi_b;
  spi_state_t  dbg_b;

  spi_initiator #(.CLK_DIV(3), .MAX_BITS(64)) u_dut_b (
    .clock(clock), .reset(reset), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_len(req_len_b), .req_tx(req_tx_b), .resp_valid(resp_valid_b), .resp_rx(resp_rx_b),
    .busy(busy_b), .sck(sck_b), .ss(ss_b), .mosi(mosi_b), .miso(mosi_b), .dbg_state(dbg_b)
  );

  // 8-bit responder: captures mosi on sck rise, shifts on sck fall, and is
  // reset to all ones by an sck rise seen while ss is high.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      rs_sr <= 8'hFF; rs_cap <= 1'b1; rs_prev <= 1'b0;
    end else begin
      rs_prev <= sck_a;
      if (sck_a && !rs_prev) begin
        if (ss_a) rs_sr <= 8'hFF;
        else      rs_cap <= mosi_a;
      end else if (!sck_a && rs_prev && !ss_a) begin
        rs_sr <= {rs_sr[6:0], rs_cap};
      end
    end
  end

  // ---------------- bus monitors (sampled on the falling clock edge) ----------------
  int   rise_lo_a = 0, rise_hi_a = 0, resp_cnt_a = 0, glitch_a = 0;
  logic prev_sck_a = 1'b0, prev_mosi_a = 1'b1;
  int   run_b = 0, gaps_b = 0, min_gap_b = 1000, glitch_b = 0, resp_cnt_b = 0;
  logic seen_low_b = 1'b0, prev_sck_b = 1'b0, prev_mosi_b = 1'b1;

  always @(negedge clock) begin
    prev_sck_a  <= sck_a;
    prev_mosi_a <= mosi_a;
    if (sck_a && !prev_sck_a) begin
      if (!ss_a) rise_lo_a <= rise_lo_a + 1;
      else       rise_hi_a <= rise_hi_a + 1;
    end
    if (sck_a && prev_sck_a && (mosi_a !== prev_mosi_a)) glitch_a <= glitch_a + 1;
    if (resp_valid_a) resp_cnt_a <= resp_cnt_a + 1;

    prev_sck_b  <= sck_b;
    prev_mosi_b <= mosi_b;
    if (sck_b && prev_sck_b && (mosi_b !== prev_mosi_b)) glitch_b <= glitch_b + 1;
    if (resp_valid_b) resp_cnt_b <= resp_cnt_b + 1;
    if (ss_b) begin
      run_b <= run_b + 1;
    end else begin
      if (run_b > 0 && seen_low_b) begin
        gaps_b <= gaps_b + 1;
        if (run_b < min_gap_b) min_gap_b <= run_b;
      end
      run_b      <= 0;
      seen_low_b <= 1'b1;
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
    end
  endtask

  // One transfer on instance A with full set of expectations.
  task automatic xfer_a(input string t, input logic [6:0] len, input logic [63:0] tx,
                        input bit noise, input int exp_lat, input logic [63:0] exp_rx,
                        input int exp_lo);
    int lat, b_lo, b_hi, b_resp;
    b_lo = rise_lo_a; b_hi = rise_hi_a; b_resp = resp_cnt_a;
    @(negedge clock);
    chk1({t, "_ready_idle"}, req_ready_a, 1'b1);
    req_valid_a = 1'b1; req_len_a = len; req_tx_a = tx;
    @(negedge clock);
    req_valid_a = 1'b0; req_len_a = 7'($urandom_range(0, 127)); req_tx_a = {$urandom, $urandom};
    chk1({t, "_ss_after_accept"}, ss_a, 1'b0);
    chk1({t, "_mosi_first"}, mosi_a, tx[63]);
    chk1({t, "_busy_after_accept"}, busy_a, 1'b1);
    chk({t, "_state_setup"}, 64'(dbg_a), 64'(ST_SETUP));
    lat = 1;
    while (resp_valid_a !== 1'b1 && lat < 400) begin
      @(negedge clock);
      lat++;
      if (noise && lat == 10) begin req_valid_a = 1'b1; req_len_a = 7'd3; end
      if (noise && lat == 14) req_valid_a = 1'b0;
    end
    chk1({t, "_resp_seen"}, resp_valid_a, 1'b1);
    chk1({t, "_ready_on_resp"}, req_ready_a, 1'b1);
    chk({t, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({t, "_rx"}, resp_rx_a, exp_rx);
    @(negedge clock);
    chk1({t, "_resp_one_cycle"}, resp_valid_a, 1'b0);
    chk({t, "_rx_held"}, resp_rx_a, exp_rx);
    chk({t, "_rises_ss_low"}, 64'(rise_lo_a - b_lo), 64'(exp_lo));
    chk({t, "_rises_ss_high"}, 64'(rise_hi_a - b_hi), 64'd1);
    chk({t, "_resp_count"}, 64'(resp_cnt_a - b_resp), 64'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n, b_lo, b_resp;
    logic [63:0] tx;
    reset = 1'b1;
    @(negedge clock);
    chk1("rst_sck", sck_a, 1'b0);
    chk1("rst_ss", ss_a, 1'b1);
    chk1("rst_mosi", mosi_a, 1'b1);
    chk1("rst_resp_valid", resp_valid_a, 1'b0);
    chk("rst_resp_rx", resp_rx_a, 64'd0);
    chk1("rst_ready", req_ready_a, 1'b1);
    chk1("rst_busy", busy_a, 1'b0);
    chk("rst_state", 64'(dbg_a), 64'(ST_IDLE));
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Loopback, 8 bits of 0xA5
    miso_sel_a = 1;
    tx = {8'hA5, 56'({$urandom, $urandom})};
    xfer_a("loop8", 7'd8, tx, 1'b0, 21, 64'h0000_0000_0000_00A5, 8);

    // Responder, 16 bits, twice; second run pokes req_valid while busy
    miso_sel_a = 2;
    xfer_a("resp16_a", 7'd16, 64'hA500_0000_0000_0000, 1'b0, 37, 64'h0000_0000_0000_FFA5, 16);
    xfer_a("resp16_b", 7'd16, 64'hA500_0000_0000_0000, 1'b1, 37, 64'h0000_0000_0000_FFA5, 16);

    // Zero-length transfer
    miso_sel_a = 0; miso_const = 1'b1;
    xfer_a("len0", 7'd0, {$urandom, $urandom}, 1'b0, 5, 64'd0, 0);

    // Over-long request clamps to 64 bits
    xfer_a("len100", 7'd100, {$urandom, $urandom}, 1'b0, 133, 64'hFFFF_FFFF_FFFF_FFFF, 64);

    // Reset during the 5th sck-high phase aborts the transfer
    miso_sel_a = 1;
    b_lo = rise_lo_a;
    @(negedge clock);
    req_valid_a = 1'b1; req_len_a = 7'd16; req_tx_a = 64'd0;
    @(negedge clock);
    req_valid_a = 1'b0;
    b_resp = resp_cnt_a;
    n = 0;
    while (!(sck_a === 1'b1 && (rise_lo_a - b_lo) == 4) && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk1("abort_reached_rise5", (n < 200), 1'b1);
    chk1("abort_ss_before", ss_a, 1'b0);
    chk1("abort_mosi_before", mosi_a, 1'b0);
    reset = 1'b1;
    #1;
    chk1("abort_sck", sck_a, 1'b0);
    chk1("abort_ss", ss_a, 1'b1);
    chk1("abort_mosi", mosi_a, 1'b1);
    chk1("abort_ready", req_ready_a, 1'b1);
    chk1("abort_resp_valid", resp_valid_a, 1'b0);
    chk("abort_rx", resp_rx_a, 64'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk1("abort_ready_after", req_ready_a, 1'b1);
    repeat (40) @(negedge clock);
    chk("abort_no_resp", 64'(resp_cnt_a - b_resp), 64'd0);
    chk("abort_rises", 64'(rise_lo_a - b_lo), 64'd5);
    chk1("abort_idle_ss", ss_a, 1'b1);

    // Back-to-back on instance B with req_valid held high
    @(negedge clock);
    req_valid_b = 1'b1; req_len_b = 7'd4; req_tx_b = 64'h9000_0000_0000_0000;
    for (int t = 0; t < 3; t++) begin
      n = 0;
      while (resp_valid_b !== 1'b1 && n < 200) begin
        @(negedge clock);
        n++;
      end
      chk1("b2b_resp_seen", resp_valid_b, 1'b1);
      chk1("b2b_ready_on_resp", req_ready_b, 1'b1);
      chk("b2b_latency", 64'(n), (t == 0) ? 64'd37 : 64'd36);
      chk("b2b_rx", resp_rx_b, 64'h9);
      if (t == 2) req_valid_b = 1'b0;
      @(negedge clock);
      chk1("b2b_busy_next", busy_b, (t < 2));
      chk1("b2b_ss_next", ss_b, (t == 2));
    end
    repeat (4) @(negedge clock);
    chk("b2b_resp_count", 64'(resp_cnt_b), 64'd3);
    chk("b2b_gap_count", 64'(gaps_b), 64'd2);
    chk1("b2b_gap_min_2div", (min_gap_b >= 6), 1'b1);

    chk("mosi_stable_a", 64'(glitch_a), 64'd0);
    chk("mosi_stable_b", 64'(glitch_b), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
